// File: rtl/ram_burst_reader.sv
// Read-side burst engine for a single-port RAM with combinational read.
// On start it walks len consecutive addresses from base_addr (wrapping modulo
// 2**ADDR_WIDTH), presents each address on raddr, captures rdata and streams
// the words out on a valid/ready interface, then pulses done for one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      burst request, only looked at in IDLE
//   abort      synchronous burst cancel, highest priority outside IDLE
//   base_addr  first RAM address of the burst
//   len        word count, 0 .. 2**ADDR_WIDTH
//   raddr      read address to the RAM (registered)
//   rdata      combinational RAM read data for raddr
//   m_data     output word (registered)
//   m_valid    m_data valid
//   m_ready    downstream accepts m_data
//   busy       high whenever the engine is not idle
//   done       one-cycle pulse at burst completion
module ram_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   RemOne  = (ADDR_WIDTH + 1)'(1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  // One bit wider than the address so a full-space burst fits.
  logic [ADDR_WIDTH:0]     remaining_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    m_valid_q;
  logic                    done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len != '0) begin
              addr_q      <= base_addr;
              remaining_q <= len;
              state_q     <= StLoad;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (abort) begin
            state_q   <= StIdle;
            m_valid_q <= 1'b0;
          end else begin
            m_data_q    <= rdata;
            m_valid_q   <= 1'b1;
            addr_q      <= addr_q + AddrOne;
            remaining_q <= remaining_q - RemOne;
            state_q     <= StSend;
          end
        end
        StSend: begin
          // An aborted beat is dropped even if m_ready is high.
          if (abort) begin
            state_q   <= StIdle;
            m_valid_q <= 1'b0;
          end else if (m_valid_q && m_ready) begin
            if (remaining_q != '0) begin
              m_data_q    <= rdata;
              addr_q      <= addr_q + AddrOne;
              remaining_q <= remaining_q - RemOne;
            end else begin
              m_valid_q <= 1'b0;
              state_q   <= StDone;
              done_q    <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign raddr   = addr_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: plain bursts, wrap-around, backpressure,
// zero and full-length bursts, abort with an ignored start, and async reset.
module tb_ram_burst_reader;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] base_addr;
  logic [4:0] len;
  logic [3:0] raddr;
  logic [7:0] rdata;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_q[$];
  int         done_cnt;

  assign rdata = mem[raddr];

  ram_burst_reader #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .len       (len),
    .raddr     (raddr),
    .rdata     (rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_word(input logic [3:0] a);
    return 8'h10 + {4'h0, a};
  endfunction

  // Runs one burst. rpat[k] is m_ready for the k-th cycle with m_valid high
  // (1 beyond bit 7). Checks latency, hold-while-stalled, words, and done.
  task automatic run_burst(input logic [3:0] b, input logic [4:0] l, input logic [7:0] rpat);
    int         k;
    int         first_v;
    int         done_at;
    int         last_hs;
    logic       seen_done;
    logic       fin;
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    logic [3:0] a;
    got_q.delete();
    done_cnt  = 0;
    k         = 0;
    first_v   = -1;
    done_at   = -1;
    last_hs   = -1;
    seen_done = 1'b0;
    fin       = 1'b0;
    pv        = 1'b0;
    pr        = 1'b0;
    pd        = '0;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    m_ready   = 1'b1;
    tick();
    start = 1'b0;
    if (l != 5'd0) check("raddr_load", {28'h0, raddr}, {28'h0, b});
    for (int c = 0; c < 64 && !fin; c++) begin
      if (pv && !pr) begin
        check("hold_valid", {31'h0, m_valid}, 32'd1);
        check("hold_data", {24'h0, m_data}, {24'h0, pd});
      end
      if (seen_done && !busy) begin
        fin = 1'b1;
      end else begin
        if (done) begin
          done_cnt++;
          if (done_at < 0) done_at = c;
          seen_done = 1'b1;
        end
        if (m_valid) begin
          if (first_v < 0) first_v = c;
          m_ready = (k < 8) ? rpat[k] : 1'b1;
          k++;
          if (m_ready) begin
            got_q.push_back(m_data);
            last_hs = c;
          end
        end else begin
          m_ready = 1'b1;
        end
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
        tick();
      end
    end
    check("burst_end", {31'h0, fin}, 32'd1);
    check("count", got_q.size(), 32'(l));
    foreach (got_q[i]) begin
      a = b + 4'(i);
      check("word", {24'h0, got_q[i]}, {24'h0, exp_word(a)});
    end
    check("done_cnt", done_cnt, 32'd1);
    check("first_valid", first_v, (l == 5'd0) ? -1 : 1);
    check("done_at", done_at, (l == 5'd0) ? 0 : last_hs + 1);
    check("idle_valid", {31'h0, m_valid}, 32'd0);
    check("idle_done", {31'h0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_valid", {31'h0, m_valid}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_raddr", {28'h0, raddr}, 32'd0);
    check("rst_data", {24'h0, m_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Plain burst, wrap-around, backpressure, empty and full-space bursts.
    run_burst(4'd3, 5'd4, 8'hff);
    run_burst(4'd14, 5'd4, 8'hff);
    run_burst(4'd0, 5'd3, 8'h34);  // ready 0,0,1,0,1,1
    run_burst(4'd0, 5'd0, 8'hff);
    run_burst(4'd5, 5'd16, 8'hff);

    // Abort during beat 2 of len=8, with a start pulsed mid-burst.
    base_addr = 4'd0;
    len       = 5'd8;
    m_ready   = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ab_v0", {31'h0, m_valid}, 32'd1);
    check("ab_d0", {24'h0, m_data}, 32'h10);
    base_addr = 4'd9;
    len       = 5'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("ab_d1", {24'h0, m_data}, 32'h11);
    check("ab_busy_mid", {31'h0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", {31'h0, busy}, 32'd0);
    check("ab_valid", {31'h0, m_valid}, 32'd0);
    check("ab_done", {31'h0, done}, 32'd0);
    tick();
    check("ab_busy2", {31'h0, busy}, 32'd0);
    check("ab_done2", {31'h0, done}, 32'd0);

    // Asynchronous reset in the middle of SEND.
    base_addr = 4'd0;
    len       = 5'd8;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", {31'h0, m_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, m_valid}, 32'd0);
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_burst(4'd2, 5'd2, 8'hff);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
